spart_rx: RTL and testbench
===========================

# spart_rx

Serial receive stage of the SPART. Oversamples the asynchronous `rxd` line using the programmed baud divisor, frames one 8N1 character (start, 8 data LSB first, stop), and hands the complete 10-bit frame to the SPART bus interface. The bus interface latches data bits [8:1] into its receive buffer and raises `rda` on the `rx_done` pulse.

## Interface
Parameters:
- `MIN_DIV`, default 4: smallest effective divisor. Smaller `divisor_buffer` values are clamped up to this.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial input from the workstation; asynchronous, idles high.
- `divisor_buffer`  in  16  baud divisor D from the bus interface.
- `rx_shift_reg`  out  10  last completed frame: [0] start bit, [8:1] data (bit 1 = first data bit received, LSB), [9] stop bit.
- `rx_done`  out  1  one-cycle pulse; frame valid, stop bit = 1.
- `framing_err`  out  1  one-cycle pulse; frame complete, stop bit = 0.
- `rx_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Input conditioning: `rxd` passes through a 2-flop synchronizer, giving `rxd_s`. Both flops reset to 1. A third flop `rxd_d` holds the previous `rxd_s`. A falling edge is `rxd_d & ~rxd_s`.
- Effective divisor: De = max(`divisor_buffer`, `MIN_DIV`). De is captured into an internal register on start detection and used for the whole frame. Changes to `divisor_buffer` mid-frame have no effect until the next frame.
- Bit period is P = De + 1 clocks. The half-period load is De >> 1.
- A 16-bit down-counter `baud_cnt` generates a sample tick when it equals 0 in an active state. On a tick it reloads De; otherwise it decrements.
- A 4-bit `bit_cnt` counts samples 0..9.
- Internal shift register `sh`: on each sample, `sh <= {rxd_s, sh[9:1]}`. After 10 samples, sh[0] holds the start bit and sh[9] holds the stop bit.
- FSM states and transitions:
  - IDLE: wait for a falling edge. On the edge, load `baud_cnt` with De >> 1, capture De, clear `bit_cnt`, and go to START.
  - START: on the tick, sample the line.
    - If `rxd_s` = 1, it was a false start: go to IDLE with no pulse and `rx_shift_reg` unchanged.
    - Otherwise shift the sample in, set `bit_cnt` = 1, and go to DATA.
  - DATA: on each tick, shift and increment `bit_cnt`. When the 9th sample is taken (`bit_cnt` becomes 9), go to STOP.
  - STOP: on the tick, take the 10th sample and go to DONE.
  - DONE: one cycle.
    - Copy `sh` to `rx_shift_reg`.
    - Pulse `rx_done` if sh[9] = 1, otherwise pulse `framing_err`.
    - Go to IDLE.
- `rx_shift_reg` changes only in DONE, including on framing errors, so it is stable between frames.
- Re-arm: edge detection needs a prior high level. After a framing error, with the line still low, no new frame starts until `rxd` returns high and falls again.
- `rx_done` and `framing_err` are never high together and are never high for two consecutive cycles.

## Timing
- Reset values: `rx_shift_reg` = 10'h000, `rx_done` = 0, `framing_err` = 0, `rx_busy` = 0, FSM = IDLE. Synchronizer and `rxd_d` reset to 1; counters reset to 0.
- Reset asserted mid-frame: all outputs return to their reset values immediately, the partial frame is discarded, and no pulse is issued after release.
- Let E be the cycle in which the falling edge is detected; this is 2–3 cycles after the `rxd` transition.
  - Start sample: E + (De >> 1) + 1.
  - Sample k (k = 0..9): E + (De >> 1) + 1 + k·P.
  - DONE and output pulse: one cycle after sample 9.
- `rx_busy` is high from E+1 through the DONE cycle inclusive.
- Back-to-back frames: a start edge arriving during the stop bit after its sample is detected on the first IDLE cycle. The edge flop state is preserved through DONE, so no frame is lost.

## Test plan
- `divisor_buffer` = 15 (P = 16), send 0x55 with a valid stop bit → exactly one `rx_done` pulse, `rx_shift_reg` = 10'h2AA. Pulse occurs 8 + 9·16 + 1 cycles after E; `framing_err` stays 0.
- Glitch: `rxd` low for 3 cycles with D = 15 → START samples 1, returns to IDLE, no pulse, `rx_shift_reg` unchanged, `rx_busy` low again.
- Framing error: send 0xA5 with stop bit = 0 → one `framing_err` pulse, `rx_done` = 0, `rx_shift_reg` = 10'h14A. No new frame starts until `rxd` rises and falls again.
- Back-to-back 0xA5 then 0x3C with no idle gap → two `rx_done` pulses, values 10'h34A then 10'h278.
- Divisor behaviour:
  - `divisor_buffer` written from 15 to 31 mid-frame → current frame still decoded at P = 16, next frame at P = 32.
  - `divisor_buffer` = 1 → clamped to De = 4, P = 5.
- Assert `rst` during DATA of a frame → outputs return to reset values at once, no `rx_done` after release. A subsequent clean 0x3C frame decodes to 10'h278.

Source files
------------

// File: rtl/spart_rx_if.sv
// rtl/spart_rx_if.sv - signal bundle between the SPART bus interface and the serial receive stage
//
// Purpose: groups the serial line, the baud divisor and the receive results.
// Signals:
//   rxd            serial input from the workstation (asynchronous, idles high)
//   divisor_buffer baud divisor D programmed by the bus interface
//   rx_shift_reg   last completed frame {stop, data[7:0], start}
//   rx_done        one-cycle pulse, frame valid (stop bit = 1)
//   framing_err    one-cycle pulse, frame complete with stop bit = 0
//   rx_busy        receiver is working on a frame
// Modports: master = bus interface side, slave = receiver side.
interface spart_rx_if;
  logic        rxd;
  logic [15:0] divisor_buffer;
  logic [9:0]  rx_shift_reg;
  logic        rx_done;
  logic        framing_err;
  logic        rx_busy;

  modport master (
    output rxd, divisor_buffer,
    input  rx_shift_reg, rx_done, framing_err, rx_busy
  );

  modport slave (
    input  rxd, divisor_buffer,
    output rx_shift_reg, rx_done, framing_err, rx_busy
  );
endinterface

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART serial receiver: oversampled 8N1 framing of the rxd line
//
// Purpose: synchronizes rxd, detects the start edge, samples the 10 bits of an
// 8N1 character at mid-bit using the programmed divisor and presents the frame.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous, active-low reset
//   bus    spart_rx_if.slave (rxd, divisor_buffer in; rx_shift_reg, rx_done,
//          framing_err, rx_busy out)
module spart_rx #(
  parameter int MIN_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  spart_rx_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_rxd_s;
  logic        r_rxd_d;
  logic [15:0] r_baud_cnt;
  logic [15:0] r_de;
  logic [3:0]  r_bit_cnt;
  logic [8:0]  r_sh;          // the nine most recent samples, newest at the top
  logic [9:0]  r_rx_shift_reg;
  logic        r_rx_done;
  logic        r_framing_err;
  logic        r_busy;

  logic [15:0] w_de;
  logic        w_fall;
  logic        w_tick;
  logic [9:0]  w_sh_next;

  assign w_de      = (bus.divisor_buffer < 16'(MIN_DIV)) ? 16'(MIN_DIV) : bus.divisor_buffer;
  assign w_fall    = r_rxd_d & ~r_rxd_s;
  assign w_tick    = (r_baud_cnt == 16'd0);
  // After the tenth sample this is the full frame with the start bit in [0].
  assign w_sh_next = {r_rxd_s, r_sh};

  assign bus.rx_shift_reg = r_rx_shift_reg;
  assign bus.rx_done      = r_rx_done;
  assign bus.framing_err  = r_framing_err;
  assign bus.rx_busy      = r_busy;

  // Edge reference holds during DONE so a start edge landing in that cycle
  // is still seen on the first IDLE cycle of a back-to-back frame.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
      r_rxd_d <= 1'b1;
    end else begin
      r_sync1 <= bus.rxd;
      r_rxd_s <= r_sync1;
      if (r_state != S_DONE) r_rxd_d <= r_rxd_s;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= S_IDLE;
      r_baud_cnt     <= 16'd0;
      r_de           <= 16'd0;
      r_bit_cnt      <= 4'd0;
      r_sh           <= 9'd0;
      r_rx_shift_reg <= 10'h000;
      r_rx_done      <= 1'b0;
      r_framing_err  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_rx_done     <= 1'b0;
      r_framing_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_baud_cnt <= w_de >> 1;   // first sample lands mid start bit
            r_de       <= w_de;
            r_bit_cnt  <= 4'd0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_baud_cnt <= r_de;
            if (r_rxd_s) begin
              r_busy  <= 1'b0;         // line high again: glitch, not a start bit
              r_state <= S_IDLE;
            end else begin
              r_sh      <= w_sh_next[9:1];
              r_bit_cnt <= 4'd1;
              r_state   <= S_DATA;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_baud_cnt <= r_de;
            r_sh       <= w_sh_next[9:1];
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd8) r_state <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_baud_cnt <= r_de;
            r_sh       <= w_sh_next[9:1];
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            // Result registers load on entry so they are visible in the DONE cycle.
            r_rx_shift_reg <= w_sh_next;
            r_rx_done      <= r_rxd_s;
            r_framing_err  <= ~r_rxd_s;
            r_state        <= S_DONE;
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - self-checking bench for spart_rx
module tb_spart_rx;
  logic clk;
  logic rst_n;

  spart_rx_if bus ();

  spart_rx #(.MIN_DIV(4)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model (timestamp arithmetic) ----------------
  int         cyc = 0;
  logic       m_frame = 1'b0;
  logic       m_dlev = 1'b1;
  logic       m_rin_prev = 1'b1;
  logic       s;
  int         m_E = 0, m_H = 0, m_P = 1, m_done_t = -1, off, k, de;
  logic [9:0] m_bits = 10'h000;
  logic [9:0] exp_reg = 10'h000;
  logic       exp_done = 1'b0, exp_ferr = 1'b0, exp_busy = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_frame = 1'b0; m_dlev = 1'b1; m_rin_prev = 1'b1;
      exp_reg = 10'h000; exp_done = 1'b0; exp_ferr = 1'b0; exp_busy = 1'b0;
    end else begin
      s = m_rin_prev;          // synchronized line seen during this cycle
      m_rin_prev = bus.rxd;
      exp_done = 1'b0;
      exp_ferr = 1'b0;
      if (m_frame) begin
        exp_busy = 1'b1;
        if (cyc == m_done_t) begin
          exp_reg = m_bits;
          if (m_bits[9]) exp_done = 1'b1; else exp_ferr = 1'b1;
          m_frame = 1'b0;
        end else begin
          off = cyc - (m_E + m_H + 1);
          if (off >= 0 && (off % m_P) == 0) begin
            k = off / m_P;
            m_bits[k] = s;
            if (k == 0 && s) m_frame = 1'b0;
            if (k == 9) m_done_t = cyc + 1;
          end
          m_dlev = s;
        end
      end else begin
        exp_busy = 1'b0;
        if (m_dlev && !s) begin
          de = (int'(bus.divisor_buffer) < 4) ? 4 : int'(bus.divisor_buffer);
          m_E = cyc; m_H = de / 2; m_P = de + 1; m_done_t = -1;
          m_frame = 1'b1;
        end
        m_dlev = s;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       cmp_en = 1'b0;
  int         done_cnt = 0, ferr_cnt = 0, dut_done_cyc = 0;
  logic [9:0] vals [0:15];

  always @(negedge clk) begin
    if (cmp_en) begin
      checks += 4;
      if (bus.rx_shift_reg !== exp_reg) begin
        failures++; $display("FAIL cyc_reg @%0d got=%h exp=%h", cyc, bus.rx_shift_reg, exp_reg);
      end
      if (bus.rx_done !== exp_done) begin
        failures++; $display("FAIL cyc_done @%0d got=%b exp=%b", cyc, bus.rx_done, exp_done);
      end
      if (bus.framing_err !== exp_ferr) begin
        failures++; $display("FAIL cyc_ferr @%0d got=%b exp=%b", cyc, bus.framing_err, exp_ferr);
      end
      if (bus.rx_busy !== exp_busy) begin
        failures++; $display("FAIL cyc_busy @%0d got=%b exp=%b", cyc, bus.rx_busy, exp_busy);
      end
      if (bus.rx_done === 1'b1) begin
        if (done_cnt < 16) vals[done_cnt] = bus.rx_shift_reg;
        done_cnt++;
        dut_done_cyc = cyc;
      end
      if (bus.framing_err === 1'b1) ferr_cnt++;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp_v);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input int per, input int nbits);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.rxd = f[i];
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.rxd = 1'b1;
    bus.divisor_buffer = 16'd15;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_reg", int'(bus.rx_shift_reg), 'h000);
    chk("reset_busy", int'(bus.rx_busy), 0);
    chk("reset_done", int'(bus.rx_done), 0);
    rst_n = 1'b1;
    idle(5);

    // 0x55, P = 16
    send(8'h55, 1'b1, 16, 10);
    idle(20);
    chk("f55_done_cnt", done_cnt, 1);
    chk("f55_ferr_cnt", ferr_cnt, 0);
    chk("f55_val", int'(vals[0]), 'h2AA);
    chk("f55_latency", dut_done_cyc - m_E, 153);

    // glitch: 3 low cycles
    bus.rxd = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    chk("glitch_done_cnt", done_cnt, 1);
    chk("glitch_reg", int'(bus.rx_shift_reg), 'h2AA);
    chk("glitch_busy", int'(bus.rx_busy), 0);

    // framing error, line held low afterwards
    send(8'hA5, 1'b0, 16, 10);
    repeat (60) @(negedge clk);
    chk("ferr_cnt", ferr_cnt, 1);
    chk("ferr_done_cnt", done_cnt, 1);
    chk("ferr_reg", int'(bus.rx_shift_reg), 'h14A);
    chk("ferr_no_rearm", int'(bus.rx_busy), 0);
    idle(20);

    // back-to-back
    send(8'hA5, 1'b1, 16, 10);
    send(8'h3C, 1'b1, 16, 10);
    idle(20);
    chk("b2b_done_cnt", done_cnt, 3);
    chk("b2b_val0", int'(vals[1]), 'h34A);
    chk("b2b_val1", int'(vals[2]), 'h278);

    // divisor changed mid-frame
    fork
      send(8'h3C, 1'b1, 16, 10);
      begin repeat (60) @(negedge clk); bus.divisor_buffer = 16'd31; end
    join
    idle(20);
    send(8'h55, 1'b1, 32, 10);
    idle(40);
    chk("div_done_cnt", done_cnt, 5);
    chk("div_val_old", int'(vals[3]), 'h278);
    chk("div_val_new", int'(vals[4]), 'h2AA);

    // clamp: D = 1 behaves as De = 4, P = 5
    bus.divisor_buffer = 16'd1;
    send(8'h3C, 1'b1, 5, 10);
    idle(20);
    chk("clamp_done_cnt", done_cnt, 6);
    chk("clamp_val", int'(vals[5]), 'h278);
    chk("clamp_latency", dut_done_cyc - m_E, 49);

    // reset during DATA
    bus.divisor_buffer = 16'd15;
    send(8'hA5, 1'b1, 16, 4);
    #1;
    rst_n = 1'b0;
    bus.rxd = 1'b1;
    #1;
    chk("rst_reg", int'(bus.rx_shift_reg), 'h000);
    chk("rst_busy", int'(bus.rx_busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(200);
    chk("rst_no_done", done_cnt, 6);
    chk("rst_no_ferr", ferr_cnt, 1);
    send(8'h3C, 1'b1, 16, 10);
    idle(20);
    chk("post_rst_cnt", done_cnt, 7);
    chk("post_rst_val", int'(vals[6]), 'h278);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
